// File: rtl/rgb_blink_warmboot.sv
// RGB LED blink sequencer and warm-boot arming FSM (RUN -> ARM -> BOOT).
// Optional macro WARMBOOT_PRIM_EN instantiates SB_WARMBOOT driven by the WB_* outputs.
module rgb_blink_warmboot #(
    parameter int         LOG2DELAY  = 22,
    parameter int         NUM_BLINKS = 16,
    parameter int         BLINK_W    = 8,
    parameter int         AUTO_BOOT  = 1,
    parameter logic [1:0] BOOT_IMAGE = 2'b11,
    parameter bit         LED_INV    = 1'b0
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [1:0]         MODE,
    input  logic               BOOT_REQ,
    input  logic [1:0]         IMAGE_SEL,
    output logic               LED_R,
    output logic               LED_G,
    output logic               LED_B,
    output logic               WB_BOOT,
    output logic               WB_S1,
    output logic               WB_S0,
    output logic [BLINK_W-1:0] BLINK_COUNT
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_ARM  = 2'd1,
        S_BOOT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [LOG2DELAY-1:0] presc_q, presc_d;
    logic                 phase_q, phase_d;
    logic [2:0]           rot_q, rot_d;
    logic [BLINK_W-1:0]   cnt_q, cnt_d;
    logic [1:0]           img_q, img_d;
    logic                 boot_q, boot_d;
    logic [2:0]           led_q, led_d;
    logic                 tick;

    assign tick = (presc_q == {LOG2DELAY{1'b1}});

    always_comb begin
        presc_d = presc_q + LOG2DELAY'(1);
        state_d = state_q;
        phase_d = phase_q;
        rot_d   = rot_q;
        cnt_d   = cnt_q;
        img_d   = img_q;
        led_d   = 3'b000;

        case (state_q)
            S_RUN: begin
                if (tick) begin
                    phase_d = ~phase_q;
                    rot_d   = {rot_q[0], rot_q[2:1]};
                    cnt_d   = (cnt_q == {BLINK_W{1'b1}}) ? cnt_q : cnt_q + BLINK_W'(1);
                end
                // An explicit request outranks an auto-boot landing on the same tick.
                if (BOOT_REQ) begin
                    state_d = S_ARM;
                    img_d   = IMAGE_SEL;
                end else if ((AUTO_BOOT != 0) && tick && (cnt_d == BLINK_W'(NUM_BLINKS))) begin
                    state_d = S_ARM;
                    img_d   = BOOT_IMAGE;
                end
            end
            S_ARM: begin
                if (tick) begin
                    state_d = S_BOOT;
                end
            end
            S_BOOT: begin
                state_d = S_BOOT;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase

        // LEDs are computed from next-state so tick and MODE effects land one cycle later.
        case (state_d)
            S_RUN: begin
                case (MODE)
                    2'd0:    led_d = {phase_d, 2'b00};
                    2'd1:    led_d = rot_d;
                    2'd2:    led_d = {3{phase_d}};
                    default: led_d = 3'b000;
                endcase
            end
            S_ARM:   led_d = 3'b111;
            default: led_d = 3'b000;
        endcase

        boot_d = (state_d == S_BOOT);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_RUN;
            presc_q <= '0;
            phase_q <= 1'b0;
            rot_q   <= 3'b100;
            cnt_q   <= '0;
            img_q   <= 2'b00;
            boot_q  <= 1'b0;
            led_q   <= {3{LED_INV}};
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            phase_q <= phase_d;
            rot_q   <= rot_d;
            cnt_q   <= cnt_d;
            img_q   <= img_d;
            boot_q  <= boot_d;
            led_q   <= led_d ^ {3{LED_INV}};
        end
    end

    assign {LED_R, LED_G, LED_B} = led_q;
    assign WB_BOOT     = boot_q;
    assign WB_S1       = img_q[1];
    assign WB_S0       = img_q[0];
    assign BLINK_COUNT = cnt_q;

`ifdef WARMBOOT_PRIM_EN
    SB_WARMBOOT u_warmboot (
        .BOOT (boot_q),
        .S1   (img_q[1]),
        .S0   (img_q[0])
    );
`else
    // Integrator wires WB_BOOT/WB_S1/WB_S0 to the warm-boot primitive.
`endif

endmodule

// File: tb/tb_rgb_blink_warmboot.sv
// Scoreboarded bench for rgb_blink_warmboot with a 16-cycle tick period.
module tb_rgb_blink_warmboot;

    logic       CLK;
    logic       RST;
    logic [1:0] MODE;
    logic       BOOT_REQ;
    logic [1:0] IMAGE_SEL;

    logic       led_r, led_g, led_b, wb_boot, wb_s1, wb_s0;
    logic [7:0] blink_count;
    logic       m_led_r, m_led_g, m_led_b, m_wb_boot, m_wb_s1, m_wb_s0;
    logic [7:0] m_blink_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          cyc;
        logic [13:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];

    rgb_blink_warmboot #(
        .LOG2DELAY(4), .NUM_BLINKS(4), .BLINK_W(8), .AUTO_BOOT(1),
        .BOOT_IMAGE(2'b10), .LED_INV(1'b0)
    ) dut (
        .CLK(CLK), .RST(RST), .MODE(MODE), .BOOT_REQ(BOOT_REQ), .IMAGE_SEL(IMAGE_SEL),
        .LED_R(led_r), .LED_G(led_g), .LED_B(led_b),
        .WB_BOOT(wb_boot), .WB_S1(wb_s1), .WB_S0(wb_s0), .BLINK_COUNT(blink_count)
    );

    rgb_blink_warmboot #(
        .LOG2DELAY(4), .NUM_BLINKS(4), .BLINK_W(8), .AUTO_BOOT(0),
        .BOOT_IMAGE(2'b11), .LED_INV(1'b0)
    ) dut_manual (
        .CLK(CLK), .RST(RST), .MODE(MODE), .BOOT_REQ(BOOT_REQ), .IMAGE_SEL(IMAGE_SEL),
        .LED_R(m_led_r), .LED_G(m_led_g), .LED_B(m_led_b),
        .WB_BOOT(m_wb_boot), .WB_S1(m_wb_s1), .WB_S0(m_wb_s0), .BLINK_COUNT(m_blink_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [13:0] obs();
        return {led_r, led_g, led_b, wb_boot, wb_s1, wb_s0, blink_count};
    endfunction

    function automatic logic [13:0] obs_manual();
        return {m_led_r, m_led_g, m_led_b, m_wb_boot, m_wb_s1, m_wb_s0, m_blink_count};
    endfunction

    // Expected outputs: {R,G,B}, {WB_BOOT,WB_S1,WB_S0}, BLINK_COUNT in a given cycle.
    function automatic void push(int c, logic [2:0] led, logic [2:0] wb, logic [7:0] cnt, string nm);
        exp_t e;
        e.cyc  = c;
        e.val  = {led, wb, cnt};
        e.name = nm;
        sb.push_back(e);
    endfunction

    // Leaves the bench #1 after the last reset edge: cycle 0 with prescaler at 0.
    task automatic do_reset();
        RST = 1'b1; BOOT_REQ = 1'b0; MODE = 2'd0; IMAGE_SEL = 2'b00;
        @(posedge CLK); @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        sb.delete();
        RST = 1'b1; BOOT_REQ = 1'b1; MODE = 2'd1; IMAGE_SEL = 2'b11;
        push(0, 3'b000, 3'b000, 8'd0, "reset_hold");
        push(1, 3'b000, 3'b000, 8'd0, "reset_hold2");
        for (int c = 0; c <= 1; c++) begin
            @(posedge CLK); #1;
            @(negedge CLK);
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                checks++;
                if (obs() !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h", e.name, c, obs(), e.val);
                end
            end
        end
        checks++;
        if (obs_manual() !== 14'h0) begin
            errors++;
            $display("FAIL reset_manual got=%h exp=%h", obs_manual(), 14'h0);
        end
        RST = 1'b0; BOOT_REQ = 1'b0;
    endtask

    task automatic test_blink_autoboot();
        exp_t e;
        sb.delete();
        do_reset();
        push(0,   3'b000, 3'b000, 8'd0, "blink_c0");
        push(15,  3'b000, 3'b000, 8'd0, "blink_pre_tick");
        push(16,  3'b100, 3'b000, 8'd1, "blink_rise16");
        push(31,  3'b100, 3'b000, 8'd1, "blink_hold31");
        push(32,  3'b000, 3'b000, 8'd2, "blink_fall32");
        push(48,  3'b100, 3'b000, 8'd3, "blink_rise48");
        push(64,  3'b111, 3'b010, 8'd4, "auto_arm64");
        push(79,  3'b111, 3'b010, 8'd4, "auto_arm79");
        push(80,  3'b000, 3'b110, 8'd4, "auto_boot80");
        push(200, 3'b000, 3'b110, 8'd4, "auto_boot200");
        for (int c = 0; c <= 200; c++) begin
            MODE = 2'd0; BOOT_REQ = 1'b0; IMAGE_SEL = 2'($urandom);
            @(negedge CLK);
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                checks++;
                if (obs() !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h", e.name, c, obs(), e.val);
                end
            end
            if (c == 64 || c == 80 || c == 200) begin
                checks++;
                if (obs_manual() !== ((c == 64) ? {3'b000, 3'b000, 8'd4} :
                                      (c == 80) ? {3'b100, 3'b000, 8'd5} :
                                                  {3'b000, 3'b000, 8'd12})) begin
                    errors++;
                    $display("FAIL no_autoboot cyc=%0d got=%h", c, obs_manual());
                end
            end
            @(posedge CLK); #1;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL blink_drain left=%0d exp=0", sb.size());
        end
    endtask

    task automatic test_rotate();
        exp_t e;
        sb.delete();
        do_reset();
        push(1,  3'b100, 3'b000, 8'd0, "rot_r1");
        push(15, 3'b100, 3'b000, 8'd0, "rot_r15");
        push(16, 3'b010, 3'b000, 8'd1, "rot_g16");
        push(32, 3'b001, 3'b000, 8'd2, "rot_b32");
        push(40, 3'b001, 3'b000, 8'd2, "rot_b40");
        push(41, 3'b000, 3'b000, 8'd2, "mode_off41");
        push(48, 3'b000, 3'b000, 8'd3, "mode_off48");
        push(51, 3'b100, 3'b000, 8'd3, "rot_back51");
        for (int c = 0; c <= 55; c++) begin
            MODE = (c >= 40 && c < 50) ? 2'd3 : 2'd1;
            BOOT_REQ = 1'b0; IMAGE_SEL = 2'($urandom);
            @(negedge CLK);
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                checks++;
                if (obs() !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h", e.name, c, obs(), e.val);
                end
            end
            @(posedge CLK); #1;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL rotate_drain left=%0d exp=0", sb.size());
        end
    endtask

    task automatic test_boot_req();
        exp_t e;
        sb.delete();
        do_reset();
        push(5,  3'b000, 3'b000, 8'd0, "req_before");
        push(6,  3'b111, 3'b001, 8'd0, "req_arm6");
        push(11, 3'b111, 3'b001, 8'd0, "req_arm_ignore");
        push(15, 3'b111, 3'b001, 8'd0, "req_arm15");
        push(16, 3'b000, 3'b101, 8'd0, "req_boot16");
        for (int c = 0; c <= 20; c++) begin
            MODE = 2'd0;
            BOOT_REQ  = (c == 5) || (c == 10);
            IMAGE_SEL = (c == 5) ? 2'b01 : 2'b10;
            @(negedge CLK);
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                checks++;
                if (obs() !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h", e.name, c, obs(), e.val);
                end
            end
            @(posedge CLK); #1;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL req_drain left=%0d exp=0", sb.size());
        end
    endtask

    task automatic test_same_cycle();
        exp_t e;
        sb.delete();
        do_reset();
        push(63, 3'b100, 3'b000, 8'd3, "same_pre");
        push(64, 3'b111, 3'b001, 8'd4, "same_arm_req_wins");
        push(80, 3'b000, 3'b101, 8'd4, "same_boot80");
        for (int c = 0; c <= 80; c++) begin
            MODE = 2'd0;
            BOOT_REQ  = (c == 63);
            IMAGE_SEL = (c == 63) ? 2'b01 : 2'b11;
            @(negedge CLK);
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                checks++;
                if (obs() !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h", e.name, c, obs(), e.val);
                end
            end
            @(posedge CLK); #1;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL same_drain left=%0d exp=0", sb.size());
        end
    endtask

    task automatic test_reset_in_arm();
        exp_t e;
        sb.delete();
        do_reset();
        push(3,  3'b111, 3'b011, 8'd0, "rarm_arm3");
        push(8,  3'b111, 3'b011, 8'd0, "rarm_arm8");
        push(9,  3'b000, 3'b000, 8'd0, "rarm_cleared9");
        push(10, 3'b000, 3'b000, 8'd0, "rarm_run10");
        push(24, 3'b000, 3'b000, 8'd0, "rarm_pre_tick24");
        push(25, 3'b100, 3'b000, 8'd1, "rarm_tick25");
        for (int c = 0; c <= 26; c++) begin
            MODE = 2'd0;
            RST       = (c == 8);
            BOOT_REQ  = (c == 2) || (c == 8);
            IMAGE_SEL = 2'b11;
            @(negedge CLK);
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                checks++;
                if (obs() !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h", e.name, c, obs(), e.val);
                end
            end
            @(posedge CLK); #1;
        end
        RST = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL rarm_drain left=%0d exp=0", sb.size());
        end
    endtask

    task automatic test_boot_ignore();
        exp_t e;
        sb.delete();
        do_reset();
        push(1,  3'b111, 3'b010, 8'd0, "ign_arm1");
        push(15, 3'b111, 3'b010, 8'd0, "ign_arm15");
        push(16, 3'b000, 3'b110, 8'd0, "ign_boot16");
        push(20, 3'b000, 3'b110, 8'd0, "ign_boot20");
        push(30, 3'b000, 3'b110, 8'd0, "ign_boot30");
        push(41, 3'b000, 3'b110, 8'd0, "ign_boot41");
        for (int c = 0; c <= 41; c++) begin
            MODE      = 2'($urandom);
            BOOT_REQ  = (c == 0) || (c >= 20 && (c % 2 == 1));
            IMAGE_SEL = (c == 0) ? 2'b10 : 2'b00;
            @(negedge CLK);
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                checks++;
                if (obs() !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h", e.name, c, obs(), e.val);
                end
            end
            @(posedge CLK); #1;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL ign_drain left=%0d exp=0", sb.size());
        end
    endtask

    initial begin
        RST = 1'b1; MODE = 2'd0; BOOT_REQ = 1'b0; IMAGE_SEL = 2'b00;
        test_reset();
        test_blink_autoboot();
        test_rotate();
        test_boot_req();
        test_same_cycle();
        test_reset_in_arm();
        test_boot_ignore();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
